cpu_mailbox_ctrl: RTL and testbench
===================================

// Module: cpu_mailbox_ctrl
// PURPOSE
//  Host-side sequencer for the RV32I core's mailbox at MBOX_BASE (SP/EP/NODE/DONE words).
//  Holds the core in reset and writes the mailbox words through the core's external memory port.
//  Then releases the core and snoops its stores, buffering NODE_POINT writes in a FIFO.
//  Ends the run on CPU_DONE=1, re-asserting core reset. Replaces hand-sequenced bench loading.
// PARAMETERS
//  MBOX_BASE      32'h0200_0000  mailbox base; SP=+0, EP=+4, NODE=+8, DONE=+C
//  NODE_W         5              node-point width (low bits of store data)
//  NODE_DEPTH     16             node FIFO depth, power of 2, >=2
//  TIMEOUT_CYCLES 100000         progress watchdog limit (MBOX_WATCHDOG_EN only)
// PORTS
//  clk            in   1        single clock, all logic on rising edge
//  reset_n        in   1        synchronous, active-low reset
//  start          in   1        1-cycle pulse: begin load+run
//  start_point    in   NODE_W   SP value, latched on accepted start
//  end_point      in   NODE_W   EP value, latched on accepted start
//  cpu_reset      out  1        core reset, active-high
//  ext_mem_write  out  1        core external-port write enable
//  ext_write_data out  32       core external-port write data
//  ext_data_adr   out  32       core external-port address
//  cpu_mem_write  in   1        core store strobe (snooped)
//  cpu_write_data in   32       core store data (snooped)
//  cpu_data_adr   in   32       core store address (snooped)
//  node_rd        in   1        pop node FIFO head
//  node_data      out  NODE_W   FIFO head (first-word-fall-through), 0 when empty
//  node_count     out  $clog2(NODE_DEPTH)+1  FIFO occupancy
//  node_overflow  out  1        sticky: node store dropped while FIFO full
//  busy / done / timeout  out 1 each  run status
// BEHAVIOUR
//  Reset (reset_n=0 at edge, any state incl. mid-run): state IDLE, cpu_reset=1, ext_*=0,
//   busy=done=timeout=node_overflow=0, FIFO emptied, node_count=0, node_data=0.
//  FSM: IDLE -> LD_SP -> LD_EP -> LD_NODE -> LD_DONE -> RUN -> {FIN | TMO}; FIN/TMO -> LD_SP on start.
//  start accepted only in IDLE/FIN/TMO: latches SP/EP; clears FIFO, overflow, done, timeout; busy=1.
//   start in LD_*/RUN ignored.
//  LD_* states: one registered write per cycle, cpu_reset=1, ext_mem_write=1, 32-bit data, zero-extended:
//   LD_SP: {SP} @+0; LD_EP: {EP} @+4; LD_NODE: 0 @+8; LD_DONE: 0 @+C. Four back-to-back cycles.
//  RUN: ext_*=0, cpu_reset=0 from the first RUN cycle. Snoop only in RUN.
//   Snooped stores are sampled on the edge that ends the store's cycle.
//   Store to +8: push cpu_write_data[NODE_W-1:0]. If FIFO full, drop the store and set node_overflow.
//   Store to +C with data==1: FIN next cycle, cpu_reset=1, busy=0, done=1 (held until start/reset).
//   Store to +C with data!=1, and stores to other addresses: ignored.
//  FIFO: node_rd on empty ignored. Simultaneous push+pop when full: both happen, no overflow.
//   Simultaneous push+pop when empty: push only, pop ignored.
//   Pointers wrap modulo NODE_DEPTH. FIFO contents persist through FIN/TMO until next start.
// CONFIGURATION
//  MBOX_WATCHDOG_EN defined: RUN-cycle counter, cleared on RUN entry and on every node push.
//   At TIMEOUT_CYCLES-1 with no DONE in that cycle: TMO next cycle, cpu_reset=1, busy=0, timeout=1.
//   If DONE and the limit hit in the same cycle, DONE wins (FIN).
//  MBOX_WATCHDOG_EN undefined: no counter; timeout tied 0; TMO unreachable; RUN waits forever.
// STRUCTURE
//  Package mbox_pkg: state enum, OFF_SP/OFF_EP/OFF_NODE/OFF_DONE (0/4/8/C), DONE_VALUE=32'h1.
//  Sub-module mbox_node_fifo: sync FWFT FIFO (push, pop, full, empty, count, data).
//  FSM, load mux, snoop decode and watchdog stay in the top.
// TESTING
//  1 SP=3, EP=11, start -> 4 consecutive ext writes (3@0200_0000, 11@..04, 0@..08, 0@..0C);
//    cpu_reset falls on the next cycle.
//  2 Core stores 3,7,11 @..08, then 1 @..0C -> node_count=3; reads give 3,7,11; done=1; cpu_reset=1.
//  3 17 node stores with no reads, DEPTH=16 -> node_count=16, node_overflow=1, head=first value;
//    with a push+pop in the same cycle while full -> count stays 16, overflow stays 0.
//  4 Store 2 @..0C, store to ..10 -> ignored, still RUN.
//    start pulse mid-RUN -> ignored; reset_n=0 mid-LD_EP -> all outputs at reset values next edge.
//  5 MBOX_WATCHDOG_EN, TIMEOUT_CYCLES=50, no stores -> timeout=1 after 50 RUN cycles;
//    DONE on cycle 49 -> done=1, timeout=0.
//  6 After FIN, second start with SP=0, EP=15 -> FIFO/flags cleared, reload sequence repeats.

Source files
------------

// File: rtl/mbox_pkg.sv
// Shared types and mailbox layout for the CPU mailbox sequencer.
// Word offsets are relative to the mailbox base address.
package mbox_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LD_SP,
      ST_LD_EP,
      ST_LD_NODE,
      ST_LD_DONE,
      ST_RUN,
      ST_FIN,
      ST_TMO
   } mbox_state_e;

   localparam logic [31:0] OFF_SP     = 32'h0000_0000;
   localparam logic [31:0] OFF_EP     = 32'h0000_0004;
   localparam logic [31:0] OFF_NODE   = 32'h0000_0008;
   localparam logic [31:0] OFF_DONE   = 32'h0000_000C;
   localparam logic [31:0] DONE_VALUE = 32'h0000_0001;

endpackage

// File: rtl/cpu_mailbox_ctrl_if.sv
// Core-facing bus: external memory write port (driven by the sequencer)
// and the core's store port (snooped by the sequencer).
interface cpu_mailbox_ctrl_if;

   logic        cpu_reset;
   logic        ext_mem_write;
   logic [31:0] ext_write_data;
   logic [31:0] ext_data_adr;
   logic        cpu_mem_write;
   logic [31:0] cpu_write_data;
   logic [31:0] cpu_data_adr;

   modport master (
      output cpu_reset, ext_mem_write, ext_write_data, ext_data_adr,
      input  cpu_mem_write, cpu_write_data, cpu_data_adr
   );

   modport slave (
      input  cpu_reset, ext_mem_write, ext_write_data, ext_data_adr,
      output cpu_mem_write, cpu_write_data, cpu_data_adr
   );

endinterface

// File: rtl/mbox_node_fifo.sv
// Synchronous first-word-fall-through FIFO for node points; head reads 0 when empty.
// Push while full is accepted only when a pop happens in the same cycle.
module mbox_node_fifo #(
   parameter int unsigned W     = 5,
   parameter int unsigned DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       flush,
   input  logic                       push,
   input  logic [W-1:0]               push_data,
   input  logic                       pop,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic [W-1:0]               data
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic [W-1:0]  r_head;

   logic          w_full;
   logic          w_empty;
   logic          w_pop;
   logic          w_push;
   logic [CW-1:0] w_count_nxt;
   logic [W-1:0]  w_head_nxt;

   assign w_full  = (r_count == CW'(DEPTH));
   assign w_empty = (r_count == '0);
   assign w_pop   = pop && !w_empty;
   assign w_push  = push && (!w_full || w_pop);

   // Head is kept registered; after a pop it comes from the slot behind the read pointer.
   always_comb begin
      w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
      w_head_nxt  = r_head;
      if (w_count_nxt == '0) begin
         w_head_nxt = '0;
      end else if (w_empty) begin
         w_head_nxt = push_data;
      end else if (w_pop) begin
         w_head_nxt = (r_count == CW'(1)) ? push_data : r_mem[PW'(r_rd_ptr + 1'b1)];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n || flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_head   <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= w_count_nxt;
         r_head  <= w_head_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push && !flush) r_mem[r_wr_ptr] <= push_data;
   end

   assign full  = w_full;
   assign empty = w_empty;
   assign count = r_count;
   assign data  = r_head;

endmodule

// File: rtl/cpu_mailbox_ctrl.sv
// Host-side mailbox sequencer: loads SP/EP/NODE/DONE into the core, runs it, snoops node stores.
// Optional progress watchdog enabled by defining MBOX_WATCHDOG_EN.
module cpu_mailbox_ctrl
   import mbox_pkg::*;
#(
   parameter logic [31:0] MBOX_BASE  = 32'h0200_0000,
   parameter int unsigned NODE_W     = 5,
   parameter int unsigned NODE_DEPTH = 16
`ifdef MBOX_WATCHDOG_EN
   , parameter int unsigned TIMEOUT_CYCLES = 100000
`endif
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          start,
   input  logic [NODE_W-1:0]             start_point,
   input  logic [NODE_W-1:0]             end_point,
   cpu_mailbox_ctrl_if.master            mbox,
   input  logic                          node_rd,
   output logic [NODE_W-1:0]             node_data,
   output logic [$clog2(NODE_DEPTH):0]   node_count,
   output logic                          node_overflow,
   output logic                          busy,
   output logic                          done,
   output logic                          timeout
);

   mbox_state_e r_state, w_state_nxt;
   logic [NODE_W-1:0] r_ep, w_ep_nxt;
   logic        r_cpu_reset, w_cpu_reset_nxt;
   logic        r_ext_we,    w_ext_we_nxt;
   logic [31:0] r_ext_wd,    w_ext_wd_nxt;
   logic [31:0] r_ext_adr,   w_ext_adr_nxt;
   logic        r_busy,      w_busy_nxt;
   logic        r_done,      w_done_nxt;
   logic        r_overflow,  w_overflow_nxt;

   logic        w_flush;
   logic        w_snoop;
   logic        w_push_req;
   logic        w_done_hit;
   logic        w_pop_eff;
   logic        w_fifo_full;
   logic        w_fifo_empty;

`ifdef MBOX_WATCHDOG_EN
   localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [WD_W-1:0] r_wd_cnt, w_wd_cnt_nxt;
   logic            r_timeout, w_timeout_nxt;
   logic            w_wd_limit;
   assign w_wd_limit = (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`endif

   assign w_snoop    = (r_state == ST_RUN) && mbox.cpu_mem_write;
   assign w_push_req = w_snoop && (mbox.cpu_data_adr == MBOX_BASE + OFF_NODE);
   assign w_done_hit = w_snoop && (mbox.cpu_data_adr == MBOX_BASE + OFF_DONE)
                       && (mbox.cpu_write_data == DONE_VALUE);
   assign w_pop_eff  = node_rd && !w_fifo_empty;

   // Next-state logic; registered outputs describe the state being entered.
   always_comb begin
      w_state_nxt     = r_state;
      w_ep_nxt        = r_ep;
      w_cpu_reset_nxt = r_cpu_reset;
      w_ext_we_nxt    = 1'b0;
      w_ext_wd_nxt    = '0;
      w_ext_adr_nxt   = '0;
      w_busy_nxt      = r_busy;
      w_done_nxt      = r_done;
      w_overflow_nxt  = r_overflow;
      w_flush         = 1'b0;
`ifdef MBOX_WATCHDOG_EN
      w_wd_cnt_nxt    = r_wd_cnt;
      w_timeout_nxt   = r_timeout;
`endif

      case (r_state)
         ST_IDLE, ST_FIN, ST_TMO: begin
            if (start) begin
               w_state_nxt     = ST_LD_SP;
               w_ep_nxt        = end_point;
               w_flush         = 1'b1;
               w_overflow_nxt  = 1'b0;
               w_done_nxt      = 1'b0;
               w_busy_nxt      = 1'b1;
               w_cpu_reset_nxt = 1'b1;
               w_ext_we_nxt    = 1'b1;
               w_ext_wd_nxt    = 32'(start_point);
               w_ext_adr_nxt   = MBOX_BASE + OFF_SP;
`ifdef MBOX_WATCHDOG_EN
               w_timeout_nxt   = 1'b0;
`endif
            end
         end
         ST_LD_SP: begin
            w_state_nxt   = ST_LD_EP;
            w_ext_we_nxt  = 1'b1;
            w_ext_wd_nxt  = 32'(r_ep);
            w_ext_adr_nxt = MBOX_BASE + OFF_EP;
         end
         ST_LD_EP: begin
            w_state_nxt   = ST_LD_NODE;
            w_ext_we_nxt  = 1'b1;
            w_ext_adr_nxt = MBOX_BASE + OFF_NODE;
         end
         ST_LD_NODE: begin
            w_state_nxt   = ST_LD_DONE;
            w_ext_we_nxt  = 1'b1;
            w_ext_adr_nxt = MBOX_BASE + OFF_DONE;
         end
         ST_LD_DONE: begin
            w_state_nxt     = ST_RUN;
            w_cpu_reset_nxt = 1'b0;
`ifdef MBOX_WATCHDOG_EN
            w_wd_cnt_nxt    = '0;
`endif
         end
         ST_RUN: begin
            if (w_push_req && w_fifo_full && !w_pop_eff) w_overflow_nxt = 1'b1;
            if (w_done_hit) begin
               w_state_nxt     = ST_FIN;
               w_cpu_reset_nxt = 1'b1;
               w_busy_nxt      = 1'b0;
               w_done_nxt      = 1'b1;
            end
`ifdef MBOX_WATCHDOG_EN
            // A node push counts as progress and restarts the watchdog.
            else if (w_push_req) begin
               w_wd_cnt_nxt = '0;
            end else if (w_wd_limit) begin
               w_state_nxt     = ST_TMO;
               w_cpu_reset_nxt = 1'b1;
               w_busy_nxt      = 1'b0;
               w_timeout_nxt   = 1'b1;
            end else begin
               w_wd_cnt_nxt = r_wd_cnt + 1'b1;
            end
`endif
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_ep        <= '0;
         r_cpu_reset <= 1'b1;
         r_ext_we    <= 1'b0;
         r_ext_wd    <= '0;
         r_ext_adr   <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_overflow  <= 1'b0;
`ifdef MBOX_WATCHDOG_EN
         r_wd_cnt    <= '0;
         r_timeout   <= 1'b0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_ep        <= w_ep_nxt;
         r_cpu_reset <= w_cpu_reset_nxt;
         r_ext_we    <= w_ext_we_nxt;
         r_ext_wd    <= w_ext_wd_nxt;
         r_ext_adr   <= w_ext_adr_nxt;
         r_busy      <= w_busy_nxt;
         r_done      <= w_done_nxt;
         r_overflow  <= w_overflow_nxt;
`ifdef MBOX_WATCHDOG_EN
         r_wd_cnt    <= w_wd_cnt_nxt;
         r_timeout   <= w_timeout_nxt;
`endif
      end
   end

   mbox_node_fifo #(
      .W     (NODE_W),
      .DEPTH (NODE_DEPTH)
   ) u_node_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (w_flush),
      .push      (w_push_req),
      .push_data (mbox.cpu_write_data[NODE_W-1:0]),
      .pop       (w_pop_eff),
      .full      (w_fifo_full),
      .empty     (w_fifo_empty),
      .count     (node_count),
      .data      (node_data)
   );

   assign mbox.cpu_reset      = r_cpu_reset;
   assign mbox.ext_mem_write  = r_ext_we;
   assign mbox.ext_write_data = r_ext_wd;
   assign mbox.ext_data_adr   = r_ext_adr;
   assign node_overflow       = r_overflow;
   assign busy                = r_busy;
   assign done                = r_done;
`ifdef MBOX_WATCHDOG_EN
   assign timeout             = r_timeout;
`else
   assign timeout             = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_mailbox_ctrl.sv
// Directed bench for cpu_mailbox_ctrl; watchdog checks run when MBOX_WATCHDOG_EN is defined.
module tb_cpu_mailbox_ctrl;

   localparam logic [31:0] BASE = 32'h0200_0000;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       start;
   logic [4:0] start_point;
   logic [4:0] end_point;
   logic       node_rd;
   logic [4:0] node_data;
   logic [4:0] node_count;
   logic       node_overflow;
   logic       busy;
   logic       done;
   logic       timeout;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   cpu_mailbox_ctrl_if mb ();

   cpu_mailbox_ctrl #(
      .MBOX_BASE  (BASE),
      .NODE_W     (5),
      .NODE_DEPTH (16)
`ifdef MBOX_WATCHDOG_EN
      , .TIMEOUT_CYCLES (50)
`endif
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .start         (start),
      .start_point   (start_point),
      .end_point     (end_point),
      .mbox          (mb),
      .node_rd       (node_rd),
      .node_data     (node_data),
      .node_count    (node_count),
      .node_overflow (node_overflow),
      .busy          (busy),
      .done          (done),
      .timeout       (timeout)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_start(input logic [4:0] sp, input logic [4:0] ep);
      start = 1'b1; start_point = sp; end_point = ep;
      cyc(1);
      start = 1'b0;
   endtask

   task automatic store(input logic [31:0] adr, input logic [31:0] dat);
      mb.cpu_mem_write = 1'b1; mb.cpu_data_adr = adr; mb.cpu_write_data = dat;
      cyc(1);
      mb.cpu_mem_write = 1'b0; mb.cpu_data_adr = '0; mb.cpu_write_data = '0;
   endtask

   task automatic chk_load(input string tag, input logic [31:0] adr, input logic [31:0] dat);
      chk({tag, "_we"},   32'(mb.ext_mem_write),  32'd1);
      chk({tag, "_adr"},  mb.ext_data_adr,         adr);
      chk({tag, "_data"}, mb.ext_write_data,       dat);
      chk({tag, "_rst"},  32'(mb.cpu_reset),       32'd1);
   endtask

   task automatic pop(input string tag, input logic [4:0] exp);
      chk(tag, 32'(node_data), 32'(exp));
      node_rd = 1'b1;
      cyc(1);
      node_rd = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_cpu_rst"}, 32'(mb.cpu_reset),      32'd1);
      chk({tag, "_we"},      32'(mb.ext_mem_write),  32'd0);
      chk({tag, "_wd"},      mb.ext_write_data,      32'd0);
      chk({tag, "_adr"},     mb.ext_data_adr,        32'd0);
      chk({tag, "_busy"},    32'(busy),              32'd0);
      chk({tag, "_done"},    32'(done),              32'd0);
      chk({tag, "_tmo"},     32'(timeout),           32'd0);
      chk({tag, "_ovf"},     32'(node_overflow),     32'd0);
      chk({tag, "_cnt"},     32'(node_count),        32'd0);
      chk({tag, "_head"},    32'(node_data),         32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_time_limit: got expired want finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      reset_n = 1'b0; start = 1'b0; start_point = '0; end_point = '0; node_rd = 1'b0;
      mb.cpu_mem_write = 1'b0; mb.cpu_data_adr = '0; mb.cpu_write_data = '0;
      cyc(2);
      chk_reset_vals("reset");
      reset_n = 1'b1;
      cyc(1);

      // Load sequence SP=3, EP=11
      do_start(5'd3, 5'd11);
      chk("t1_busy", 32'(busy), 32'd1);
      chk_load("t1_sp", BASE + 32'h0, 32'd3);
      cyc(1); chk_load("t1_ep",   BASE + 32'h4, 32'd11);
      cyc(1); chk_load("t1_node", BASE + 32'h8, 32'd0);
      cyc(1); chk_load("t1_done", BASE + 32'hC, 32'd0);
      cyc(1);
      chk("t1_run_we",  32'(mb.ext_mem_write), 32'd0);
      chk("t1_run_rst", 32'(mb.cpu_reset),     32'd0);

      // Node stores then DONE
      store(BASE + 32'h8, 32'hFFFF_FFE3);
      chk("t2_cnt1",  32'(node_count), 32'd1);
      chk("t2_head1", 32'(node_data),  32'd3);
      store(BASE + 32'h8, 32'd7);
      store(BASE + 32'h8, 32'd11);
      chk("t2_cnt3",  32'(node_count), 32'd3);
      chk("t2_head3", 32'(node_data),  32'd3);
      store(BASE + 32'hC, 32'd1);
      chk("t2_done", 32'(done),         32'd1);
      chk("t2_rst",  32'(mb.cpu_reset), 32'd1);
      chk("t2_busy", 32'(busy),         32'd0);
      store(BASE + 32'h8, 32'd9);
      chk("t2_fin_no_snoop", 32'(node_count), 32'd3);
      pop("t2_rd0", 5'd3);
      pop("t2_rd1", 5'd7);
      chk("t2_left_cnt",  32'(node_count), 32'd1);
      chk("t2_left_head", 32'(node_data),  32'd11);

      // Restart from FIN with SP=0, EP=15
      do_start(5'd0, 5'd15);
      chk("t6_done_clr", 32'(done),       32'd0);
      chk("t6_busy",     32'(busy),       32'd1);
      chk("t6_cnt_clr",  32'(node_count), 32'd0);
      chk("t6_head_clr", 32'(node_data),  32'd0);
      chk_load("t6_sp", BASE + 32'h0, 32'd0);
      cyc(1); chk_load("t6_ep",   BASE + 32'h4, 32'd15);
      cyc(1); chk_load("t6_node", BASE + 32'h8, 32'd0);
      cyc(1); chk_load("t6_done", BASE + 32'hC, 32'd0);
      cyc(1);
      chk("t6_run_rst", 32'(mb.cpu_reset), 32'd0);

      // Ignored stores and start while running
      store(BASE + 32'hC, 32'd2);
      chk("t4_done2_done", 32'(done),         32'd0);
      chk("t4_done2_rst",  32'(mb.cpu_reset), 32'd0);
      store(BASE + 32'h10, 32'd5);
      chk("t4_other_cnt", 32'(node_count), 32'd0);
      chk("t4_other_busy", 32'(busy),      32'd1);
      do_start(5'd1, 5'd2);
      chk("t4_start_we",  32'(mb.ext_mem_write), 32'd0);
      chk("t4_start_rst", 32'(mb.cpu_reset),     32'd0);
`ifndef MBOX_WATCHDOG_EN
      cyc(60);
      chk("t5_nowd_tmo",  32'(timeout), 32'd0);
      chk("t5_nowd_busy", 32'(busy),    32'd1);
`endif

      // Fill to full, push+pop while full, then overflow
      for (int i = 1; i <= 16; i++) store(BASE + 32'h8, 32'(i));
      chk("t3_full_cnt",  32'(node_count),    32'd16);
      chk("t3_full_ovf",  32'(node_overflow), 32'd0);
      chk("t3_full_head", 32'(node_data),     32'd1);
      node_rd = 1'b1;
      store(BASE + 32'h8, 32'd20);
      node_rd = 1'b0;
      chk("t3_pp_cnt",  32'(node_count),    32'd16);
      chk("t3_pp_ovf",  32'(node_overflow), 32'd0);
      chk("t3_pp_head", 32'(node_data),     32'd2);
      store(BASE + 32'h8, 32'd21);
      chk("t3_ovf_cnt",  32'(node_count),    32'd16);
      chk("t3_ovf",      32'(node_overflow), 32'd1);
      chk("t3_ovf_head", 32'(node_data),     32'd2);
      store(BASE + 32'hC, 32'd1);
      chk("t3_fin_done", 32'(done),       32'd1);
      chk("t3_fin_cnt",  32'(node_count), 32'd16);
      for (int i = 2; i <= 16; i++) pop($sformatf("t3_drain%0d", i), 5'(i));
      pop("t3_drain_last", 5'd20);
      chk("t3_empty_cnt",  32'(node_count), 32'd0);
      chk("t3_empty_head", 32'(node_data),  32'd0);
      node_rd = 1'b1; cyc(1); node_rd = 1'b0;
      chk("t3_rd_empty_cnt", 32'(node_count), 32'd0);
      chk("t3_ovf_sticky",   32'(node_overflow), 32'd1);

      // Reset in the middle of LD_EP
      do_start(5'd5, 5'd9);
      chk("t4_ovf_clr", 32'(node_overflow), 32'd0);
      cyc(1);
      chk_load("t4_ep", BASE + 32'h4, 32'd9);
      reset_n = 1'b0;
      cyc(1);
      chk_reset_vals("t4_midrst");
      reset_n = 1'b1;
      cyc(1);
      chk("t4_idle_we", 32'(mb.ext_mem_write), 32'd0);

`ifdef MBOX_WATCHDOG_EN
      // Watchdog expiry after 50 RUN cycles, then DONE on the final cycle wins
      do_start(5'd1, 5'd2);
      cyc(4);
      chk("t5_run_rst", 32'(mb.cpu_reset), 32'd0);
      cyc(49);
      chk("t5_c49_tmo",  32'(timeout), 32'd0);
      chk("t5_c49_busy", 32'(busy),    32'd1);
      cyc(1);
      chk("t5_tmo",      32'(timeout),      32'd1);
      chk("t5_tmo_rst",  32'(mb.cpu_reset), 32'd1);
      chk("t5_tmo_busy", 32'(busy),         32'd0);
      chk("t5_tmo_done", 32'(done),         32'd0);
      do_start(5'd1, 5'd2);
      chk("t5_restart_tmo", 32'(timeout), 32'd0);
      cyc(4);
      cyc(49);
      store(BASE + 32'hC, 32'd1);
      chk("t5_race_done", 32'(done),    32'd1);
      chk("t5_race_tmo",  32'(timeout), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
